// File: rtl/mem_lsu.sv
// Load/store initiator between the RiSC-16 MEM stage and a negedge data memory.
// Optional out-of-range address checking is enabled by defining LSU_RANGE_CHK_EN.
module mem_lsu #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [p_WORD_LEN-1:0] i_req_addr,
  input  logic [p_WORD_LEN-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [p_WORD_LEN-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [p_ADDR_LEN-1:0] addr_q, addr_d;
  logic [p_WORD_LEN-1:0] wdata_q, wdata_d;
  logic [p_WORD_LEN-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  addr_hi_nz;
  logic                  out_of_range;

  generate
    if (p_ADDR_LEN < p_WORD_LEN) begin : g_addr_hi
      assign addr_hi_nz = |i_req_addr[p_WORD_LEN-1:p_ADDR_LEN];
    end else begin : g_no_addr_hi
      assign addr_hi_nz = 1'b0;
    end
  endgenerate

`ifdef LSU_RANGE_CHK_EN
  assign out_of_range = addr_hi_nz;
`else
  // Upper address bits are deliberately ignored; the address simply truncates.
  logic unused_addr_hi;
  assign unused_addr_hi = addr_hi_nz;
  assign out_of_range   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr[p_ADDR_LEN-1:0];
          wdata_d = i_req_wdata;
          if (out_of_range) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // Memory registered its read word on the negedge inside this cycle.
        rdata_d = we_q ? '0 : i_mem_rd_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready   = (state_q == S_IDLE);
  assign o_rsp_valid   = (state_q == S_RESP);
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_err     = err_q;
  assign o_mem_wr_en   = (state_q == S_ACCESS) && we_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a negedge-registered data memory model.
module tb_mem_lsu;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [15:0] i_req_addr;
  logic [15:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [15:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_mem_wr_en;
  logic [9:0]  o_mem_addr;
  logic [15:0] o_mem_wr_data;
  logic [15:0] i_mem_rd_data;

  logic [15:0] mem [0:1023];
  int          total_cnt;
  int          bad_cnt;
  int          wr_cnt;
  int          wr_base;
  logic [15:0] held_rdata;

  mem_lsu #(.p_WORD_LEN(16), .p_ADDR_LEN(10)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_wr_en  (o_mem_wr_en),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data),
    .i_mem_rd_data(i_mem_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Data memory: writes and registers read data on the falling edge.
  always @(negedge i_clk) begin
    if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_wr_data;
    i_mem_rd_data <= mem[o_mem_addr];
  end

  always @(posedge i_clk) begin
    if (o_mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request from S_IDLE and consume its response (i_rsp_ready held 1).
  task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input logic exp_err);
    chk({tag, "_idle_ready"}, o_req_ready, 1'b1);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    tick();
    i_req_valid = 1'b0;
    chk({tag, "_busy_ready"}, o_req_ready, 1'b0);
    if (!exp_err) begin
      chk({tag, "_acc_wr_en"}, o_mem_wr_en, we);
      chk({tag, "_acc_addr"}, o_mem_addr, addr[9:0]);
      tick();
    end
    chk({tag, "_rsp_valid"}, o_rsp_valid, 1'b1);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, exp_rdata);
    chk({tag, "_rsp_err"}, o_rsp_err, exp_err);
    chk({tag, "_rsp_wr_en"}, o_mem_wr_en, 1'b0);
    tick();
    chk({tag, "_done_valid"}, o_rsp_valid, 1'b0);
  endtask

  initial begin
    total_cnt   = 0;
    bad_cnt     = 0;
    wr_cnt      = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = 16'h0000;
    i_req_wdata = 16'h0000;
    i_rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", o_req_ready, 1'b1);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", o_rsp_rdata, 16'h0000);
    chk("rst_rsp_err", o_rsp_err, 1'b0);
    chk("rst_mem_wr_en", o_mem_wr_en, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 10'h000);
    chk("rst_mem_wdata", o_mem_wr_data, 16'h0000);
    i_rst_n = 1'b1;
    tick();

    // Store then load back; the write strobe lasts exactly one cycle.
    wr_base = wr_cnt;
    do_req("st_005", 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
    chk("st_005_wr_cycles", wr_cnt - wr_base, 1);
    chk("st_005_mem", mem[5], 16'hBEEF);
    do_req("ld_005", 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);

    // Boundary addresses.
    do_req("ld_3ff", 1'b0, 16'h03FF, 16'h0000, 16'h0000, 1'b0);
    do_req("st_000", 1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0);
    do_req("ld_000", 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0);

    // Response backpressure with a competing request held valid.
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 16'h0005;
    tick();
    i_req_we    = 1'b1;
    i_req_addr  = 16'h0000;
    i_req_wdata = 16'h7777;
    tick();
    held_rdata = 16'hBEEF;
    wr_base    = wr_cnt;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_%0d", c), o_rsp_valid, 1'b1);
      chk($sformatf("bp_rdata_%0d", c), o_rsp_rdata, held_rdata);
      chk($sformatf("bp_ready_%0d", c), o_req_ready, 1'b0);
      tick();
    end
    chk("bp_no_wr", wr_cnt - wr_base, 0);
    chk("bp_mem_000", mem[0], 16'h1234);
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", o_rsp_valid, 1'b0);
    chk("bp_release_ready", o_req_ready, 1'b1);

    // Store with upper address bits set.
    wr_base = wr_cnt;
`ifdef LSU_RANGE_CHK_EN
    do_req("st_405", 1'b1, 16'h0405, 16'hAAAA, 16'h0000, 1'b1);
    chk("st_405_no_wr", wr_cnt - wr_base, 0);
    chk("st_405_mem_005", mem[5], 16'hBEEF);
`else
    do_req("st_405", 1'b1, 16'h0405, 16'hAAAA, 16'h0000, 1'b0);
    chk("st_405_wr_cycles", wr_cnt - wr_base, 1);
    chk("st_405_mem_005", mem[5], 16'hAAAA);
`endif

    // Reset during the access cycle of a store.
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = 16'h0010;
    i_req_wdata = 16'h5555;
    tick();
    i_req_valid = 1'b0;
    chk("rs_acc_wr_en", o_mem_wr_en, 1'b1);
    i_rst_n = 1'b0;
    tick();
    chk("rs_req_ready", o_req_ready, 1'b1);
    chk("rs_rsp_valid", o_rsp_valid, 1'b0);
    chk("rs_rsp_rdata", o_rsp_rdata, 16'h0000);
    chk("rs_rsp_err", o_rsp_err, 1'b0);
    chk("rs_mem_wr_en", o_mem_wr_en, 1'b0);
    chk("rs_mem_addr", o_mem_addr, 10'h000);
    chk("rs_mem_wdata", o_mem_wr_data, 16'h0000);
    chk("rs_mem_010", mem[16], 16'h5555);
    i_rst_n = 1'b1;
    tick();
    tick();
    chk("rs_no_rsp", o_rsp_valid, 1'b0);
    do_req("ld_010", 1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
